mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port arbiter (instruction fetch and data) in front of a
//               single-ported unified memory with a fixed access latency.
//               Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              if_stall,
    output logic              dm_stall,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] c_last_cnt = 4'(MEM_LAT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_gnt_data;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic              w_req_any;
    logic              w_grant_data;
    logic              w_last;
    logic              w_mem_en;
    logic              w_if_ack;
    logic              w_dm_ack;
    logic              w_busy;

    assign w_req_any = if_req | dm_req;
    assign w_last    = (r_cnt == c_last_cnt);

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [1:0] r_starve;
    logic       w_force_fetch;

    // Once fetch has lost STARVE_MAX contentions in a row it wins the next one.
    assign w_force_fetch = (r_starve == 2'(STARVE_MAX));
    assign w_grant_data  = dm_req & ~(if_req & w_force_fetch);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 2'd0;
        end else if (r_state == IDLE && w_req_any) begin
            if (!w_grant_data) begin
                r_starve <= 2'd0;
            end else if (if_req) begin
                r_starve <= r_starve + 2'd1;
            end
        end
    end
`else
    localparam int c_unused_starve_max = STARVE_MAX;

    assign w_grant_data = dm_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_en    = 1'b0;
        w_if_ack    = 1'b0;
        w_dm_ack    = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_req_any) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_mem_en = 1'b1;
                if (w_last) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_if_ack    = ~r_gnt_data;
                w_dm_ack    = r_gnt_data;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant, address and store data are frozen on the IDLE->ACCESS edge so the
    // memory sees a stable request even if the requester drops it mid-access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_gnt_data <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_any) begin
                        r_cnt      <= 4'd0;
                        r_gnt_data <= w_grant_data;
                        r_we       <= w_grant_data & dm_we;
                        r_addr     <= w_grant_data ? dm_addr : if_addr;
                        r_wdata    <= w_grant_data ? dm_wdata : '0;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        if (!r_gnt_data) begin
                            r_if_rdata <= mem_rdata;
                        end else if (!r_we) begin
                            r_dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_en    = w_mem_en;
    assign mem_we    = w_mem_en & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_ack    = w_if_ack;
    assign dm_ack    = w_dm_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

    assign if_stall  = if_req & ~w_if_ack;
    assign dm_stall  = dm_req & ~w_dm_ack;
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int MEM_LAT    = 4;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              if_stall;
    logic              dm_stall;
    logic              busy;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_LAT   (MEM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ack   (dm_ack),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .if_stall (if_stall),
        .dm_stall (dm_stall),
        .busy     (busy)
    );

    typedef struct {
        bit          is_data;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          gcyc;
    } txn_t;

    txn_t        sbq[$];
    int          cyc = 0;
    int          free_at = 0;
    int          losses = 0;
    logic [15:0] exp_if_rdata = '0;
    logic [15:0] exp_dm_rdata = '0;
    bit          exp_zero = 1'b0;
    bit          if_granted = 1'b0;
    bit          dm_granted = 1'b0;
    bit          use_force = 1'b0;
    logic [15:0] force_rdata = '0;
    bit          mon_on = 1'b0;
    bit          if_pend = 1'b0;
    bit          dm_pend = 1'b0;
    int          n_if_ack = 0;
    int          n_dm_ack = 0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one access at a time, each occupying MEM_LAT+2 cycles
    // from the cycle the request is seen; data wins contention by default.
    always @(posedge clk) begin
        if (rst) begin
            sbq.delete();
            free_at      = cyc + 1;
            losses       = 0;
            exp_if_rdata = '0;
            exp_dm_rdata = '0;
            exp_zero     = 1'b1;
            if_granted   = 1'b0;
            dm_granted   = 1'b0;
        end else begin
            if (sbq.size() > 0 && cyc == sbq[0].gcyc + MEM_LAT) begin
                if (!sbq[0].is_data) exp_if_rdata = sbq[0].rdata;
                else if (!sbq[0].we) exp_dm_rdata = sbq[0].rdata;
            end
            if (cyc >= free_at && (if_req || dm_req)) begin
                txn_t t;
                bit   pick_data;
                pick_data = dm_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
                if (dm_req && if_req && losses >= STARVE_MAX) pick_data = 1'b0;
`endif
                t.is_data = pick_data;
                t.we      = pick_data && dm_we;
                t.addr    = pick_data ? dm_addr : if_addr;
                t.wdata   = dm_wdata;
                t.rdata   = use_force ? force_rdata : mem_fn(t.addr);
                t.gcyc    = cyc;
                sbq.push_back(t);
                if (pick_data) dm_granted = 1'b1;
                else           if_granted = 1'b1;
                if (pick_data && if_req) losses++;
                else if (!pick_data)     losses = 0;
                free_at  = cyc + MEM_LAT + 2;
                exp_zero = 1'b0;
            end
        end
        cyc++;
    end

    // Memory returns the expected word only in the last access cycle.
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0 && cyc == sbq[0].gcyc + MEM_LAT) mem_rdata = sbq[0].rdata;
        else mem_rdata = 16'($urandom);
    end

    always @(negedge clk) begin
        txn_t h;
        bit   has;
        bit   in_acc;
        bit   in_rsp;
        bit   e_if_ack;
        bit   e_dm_ack;
        if (mon_on) begin
            has    = (sbq.size() > 0);
            in_acc = 1'b0;
            in_rsp = 1'b0;
            if (has) begin
                h      = sbq[0];
                in_acc = (cyc > h.gcyc) && (cyc <= h.gcyc + MEM_LAT);
                in_rsp = (cyc == h.gcyc + MEM_LAT + 1);
            end
            e_if_ack = in_rsp && !h.is_data;
            e_dm_ack = in_rsp && h.is_data;
            chk("busy", busy, in_acc || in_rsp);
            chk("mem_en", mem_en, in_acc);
            chk("if_ack", if_ack, e_if_ack);
            chk("dm_ack", dm_ack, e_dm_ack);
            chk("if_stall", if_stall, if_req & ~e_if_ack);
            chk("dm_stall", dm_stall, dm_req & ~e_dm_ack);
            chk("if_rdata", if_rdata, exp_if_rdata);
            chk("dm_rdata", dm_rdata, exp_dm_rdata);
            if (in_acc) begin
                chk("mem_addr", mem_addr, h.addr);
                chk("mem_we", mem_we, h.is_data && h.we);
                if (h.is_data && h.we) chk("mem_wdata", mem_wdata, h.wdata);
            end
            if (exp_zero) begin
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_mem_we", mem_we, 0);
            end
            if (in_rsp) begin
                if (h.is_data) dm_granted = 1'b0;
                else           if_granted = 1'b0;
                void'(sbq.pop_front());
            end else if (has && cyc > h.gcyc + MEM_LAT + 1) begin
                checks++;
                errors++;
                $display("FAIL ack_timeout: no ack for grant at cycle %0d (now %0d)", h.gcyc, cyc);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic step(input int pct_if, input int pct_dm);
        @(posedge clk);
        #1;
        if (if_ack) begin if_pend = 1'b0; n_if_ack++; end
        if (dm_ack) begin dm_pend = 1'b0; n_dm_ack++; end
        if (!if_pend) begin
            if ($urandom_range(99) < pct_if) begin
                if_pend = 1'b1;
                if_req  = 1'b1;
                if_addr = 16'($urandom);
            end else begin
                if_req = 1'b0;
            end
        end else if (if_granted && $urandom_range(7) == 0) begin
            if_req = 1'b0;
        end
        if (!dm_pend) begin
            if ($urandom_range(99) < pct_dm) begin
                dm_pend  = 1'b1;
                dm_req   = 1'b1;
                dm_we    = 1'($urandom_range(1));
                dm_addr  = 16'($urandom);
                dm_wdata = 16'($urandom);
            end else begin
                dm_req = 1'b0;
            end
        end else if (dm_granted && $urandom_range(7) == 0) begin
            dm_req = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((if_pend || dm_pend) && n < 200) begin
            step(0, 0);
            n++;
        end
        checks++;
        if (if_pend || dm_pend) begin
            errors++;
            $display("FAIL wait_idle: requests still pending if=%0d dm=%0d", if_pend, dm_pend);
            if_pend = 1'b0; dm_pend = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        end
        step(0, 0);
        step(0, 0);
    endtask

    initial begin
        int a0;
        int d0;
        // Reset held two cycles with a fetch request pending.
        if_req  = 1'b1;
        if_addr = 16'h0010;
        @(posedge clk);
        #1 mon_on = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        if_req = 1'b0;

        // Fetch with a known memory word.
        use_force = 1'b1; force_rdata = 16'hB123;
        if_req = 1'b1; if_addr = 16'h0010; if_pend = 1'b1;
        wait_idle();
        use_force = 1'b0;

        // Store: dm_rdata must keep its previous value.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h8000; dm_wdata = 16'h00FF; dm_pend = 1'b1;
        wait_idle();

        // Simultaneous requests: data first, fetch straight after.
        if_req = 1'b1; if_addr = 16'h0200; if_pend = 1'b1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h1234; dm_pend = 1'b1;
        wait_idle();

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 200; i++) begin
                case (k)
                    0:       step(60, 60);
                    1:       step(30, 90);
                    default: step(90, 30);
                endcase
            end
        end
        wait_idle();

        // Reset in the third access cycle: access abandoned, no ack.
        if_req = 1'b1; if_addr = 16'h0420; if_pend = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        if_req = 1'b0; if_pend = 1'b0; dm_req = 1'b0; dm_pend = 1'b0;
        a0 = n_if_ack + n_dm_ack;
        repeat (8) step(0, 0);
        chk("rst_no_ack", n_if_ack + n_dm_ack - a0, 0);

        // Continuous contention after reset.
        a0 = n_if_ack;
        d0 = n_dm_ack;
        for (int i = 0; i < 100 && (n_if_ack + n_dm_ack - a0 - d0) < 5; i++) step(100, 100);
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("starve_fetch_grants", n_if_ack - a0, 1);
`else
        chk("starve_fetch_grants", n_if_ack - a0, 0);
`endif
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
